md_issue_ctrl: RTL and testbench
================================

// Module: md_issue_ctrl
// PURPOSE
// - D-stage initiator for the E-stage multiply/divide unit: classifies the D instruction and issues MD start ops over a req/ack handshake.
// - Holds a shadow busy countdown that mirrors the MD unit's latency.
// - Stalls F/D and injects an E bubble while any HI/LO-class instruction in D must wait.
// PARAMETERS
// - MUL_LAT  5   cycles from ack to HI/LO valid for mult/multu/madd/msub
// - DIV_LAT  10  cycles from ack to HI/LO valid for div/divu
// - CNT_W    4   countdown width; must hold max(MUL_LAT, DIV_LAT)
// PORTS
// - clk          in   1      clock, rising edge
// - rst          in   1      reset, synchronous, active-high
// - d_instr      in   32     instruction in D
// - d_valid      in   1      d_instr is a real instruction (0 = bubble)
// - e_stall_ext  in   1      pipeline frozen by another hazard source
// - md_ack       in   1      MD unit accepted the pending start op
// - md_req       out  1      start op pending (registered)
// - md_op        out  3      start op code, md_defs::MD_* (registered, held with md_req)
// - md_busy_cnt  out  CNT_W  shadow countdown, 0 = idle
// - d_md_stall   out  1      freeze F/D
// - e_bubble     out  1      insert NOP into E; equals d_md_stall
// BEHAVIOUR
// - Classes: START = mult, multu, div, divu (+ madd, msub under the macro); HL = mfhi, mflo, mthi, mtlo; all others are OTHER.
// - FSM states: IDLE, ISSUE, WAIT.
// - IDLE -> ISSUE when d_valid & START & !e_stall_ext.
//   - Registers md_req=1 and md_op.
//   - The start instruction stays in D; d_md_stall=1.
// - ISSUE: md_req and md_op held stable until md_ack.
//   - d_md_stall=1 except in the md_ack cycle, which releases the instruction to E.
//   - On md_ack: md_req<=0, cnt<=MUL_LAT or DIV_LAT per op, go to WAIT.
// - WAIT: cnt decrements every cycle, including while e_stall_ext=1; the MD unit runs freely.
//   - d_md_stall = d_valid & (START | HL). OTHER instructions pass with no stall.
//   - When cnt==1: cnt<=0 and go to IDLE. A START waiting in D moves to ISSUE on the next cycle, so back-to-back ops issue 1 cycle after idle.
// - d_md_stall is combinational from state, cnt and the d_instr class. It is 0 in IDLE.
// - md_ack outside ISSUE is ignored. No timeout on md_ack.
// - e_stall_ext in ISSUE: md_req stays held and the ack is still accepted.
// - Divide by zero is not special-cased; DIV_LAT applies.
// - Reset (any state, mid-op included): state=IDLE, cnt=0, md_req=0, md_op=0, d_md_stall=0, e_bubble=0.
// CONFIGURATION
// - Macro MD_ISSUE_MADD_EN.
// - Defined: madd (opcode 011100, funct 000000) and msub (opcode 011100, funct 000100) are START class, md_op MD_MADD/MD_MSUB, latency MUL_LAT.
// - Undefined: both decode as OTHER and never stall or issue.
// STRUCTURE
// - Package md_defs holds:
//   - opcode/funct constants (SPECIAL 000000, SPECIAL2 011100; funct MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MADD 000000, MSUB 000100)
//   - md_op_t enum: MD_NONE=0, MULT, MULTU, DIV, DIVU, MADD, MSUB
//   - FSM state enum
// - Sub-module md_decode: combinational classifier, d_instr -> {is_start, is_hl, md_op, lat_sel}. Shared with the E-stage unit.
// - Top holds the FSM, countdown and output registers.
// TESTING
// - mult at IDLE: md_req=1 next cycle, md_op=MULT. Ack 2 cycles later: stall drops in the ack cycle, cnt=5,4,3,2,1,0.
// - mflo in D right after the mult: d_md_stall=e_bubble=1 for 5 cycles, released when cnt reaches 0.
// - div, then addu in D during WAIT: addu passes with no stall. A following mfhi stalls until the 10-cycle count expires.
// - Back-to-back mult, multu: second md_req rises exactly 1 cycle after cnt hits 0. md_op=MULTU.
// - e_stall_ext=1 for 3 cycles mid-WAIT: cnt keeps decrementing. Stray md_ack in WAIT: no effect.
// - rst at cnt=7 in WAIT: next cycle IDLE, cnt=0, md_req=0, stall=0.
// - madd: with macro defined, issues md_op=MADD and cnt=5. Without macro, no md_req and no stall.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared multiply/divide definitions: opcode/funct constants, start-op codes and the
// issue FSM state encoding. Used by md_decode, md_issue_ctrl and the E-stage MD unit.
package md_defs;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MADD  = 6'b000000;
    localparam logic [5:0] FN_MSUB  = 6'b000100;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MADD  = 3'd5,
        MD_MSUB  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Start-op channel between the D-stage issue controller (master) and the MD unit (slave).
interface md_issue_ctrl_if;
    import md_defs::*;

    // md_req is the valid, md_ack the ready: an op transfers in the cycle both are 1;
    // md_req and md_op stay stable from assertion until that transfer cycle.
    logic   md_req;
    md_op_t md_op;
    logic   md_ack;

    modport master (output md_req, output md_op, input md_ack);
    modport slave  (input md_req, input md_op, output md_ack);

endinterface

// File: rtl/md_issue_ctrl_decode.sv
// Combinational MD classifier for the D instruction; madd/msub are START class only
// when MD_ISSUE_MADD_EN is defined, otherwise they decode as OTHER.
module md_decode
    import md_defs::*;
(
    input  logic [31:0] instr_i,
    output logic        is_start_o,
    output logic        is_hl_o,
    output md_op_t      md_op_o,
    output logic        lat_sel_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    // lat_sel_o = 1 selects the divide latency
    always_comb begin
        is_start_o = 1'b0;
        is_hl_o    = 1'b0;
        md_op_o    = MD_NONE;
        lat_sel_o  = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_MULT:  begin is_start_o = 1'b1; md_op_o = MD_MULT;  end
                FN_MULTU: begin is_start_o = 1'b1; md_op_o = MD_MULTU; end
                FN_DIV:   begin is_start_o = 1'b1; md_op_o = MD_DIV;  lat_sel_o = 1'b1; end
                FN_DIVU:  begin is_start_o = 1'b1; md_op_o = MD_DIVU; lat_sel_o = 1'b1; end
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: is_hl_o = 1'b1;
                default: ;
            endcase
        end
`ifdef MD_ISSUE_MADD_EN
        else if (opcode == OP_SPECIAL2) begin
            case (funct)
                FN_MADD: begin is_start_o = 1'b1; md_op_o = MD_MADD; end
                FN_MSUB: begin is_start_o = 1'b1; md_op_o = MD_MSUB; end
                default: ;
            endcase
        end
`else
        else begin
            is_start_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// D-stage multiply/divide issue controller: issues start ops, shadows MD latency with a
// countdown and stalls F/D while HI/LO users must wait. Optional madd/msub: MD_ISSUE_MADD_EN.
module md_issue_ctrl
    import md_defs::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       d_instr,
    input  logic              d_valid,
    input  logic              e_stall_ext,
    md_issue_ctrl_if.master   md_if,
    output logic [CNT_W-1:0]  md_busy_cnt,
    output logic              d_md_stall,
    output logic              e_bubble,
    output md_state_t         dbg_state
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_req_q, md_req_d;
    md_op_t           md_op_q, md_op_d;
    logic             lat_div_q, lat_div_d;

    logic   dec_start;
    logic   dec_hl;
    md_op_t dec_op;
    logic   dec_lat;

    md_decode u_decode (
        .instr_i    (d_instr),
        .is_start_o (dec_start),
        .is_hl_o    (dec_hl),
        .md_op_o    (dec_op),
        .lat_sel_o  (dec_lat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            md_req_q  <= 1'b0;
            md_op_q   <= MD_NONE;
            lat_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_req_q  <= md_req_d;
            md_op_q   <= md_op_d;
            lat_div_q <= lat_div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_req_d  = md_req_q;
        md_op_d   = md_op_q;
        lat_div_d = lat_div_q;
        case (state_q)
            ST_IDLE: begin
                if (d_valid && dec_start && !e_stall_ext) begin
                    state_d   = ST_ISSUE;
                    md_req_d  = 1'b1;
                    md_op_d   = dec_op;
                    lat_div_d = dec_lat;
                end
            end
            ST_ISSUE: begin
                if (md_if.md_ack) begin
                    state_d  = ST_WAIT;
                    md_req_d = 1'b0;
                    cnt_d    = lat_div_q ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
            end
            ST_WAIT: begin
                // The MD unit runs freely, so external freezes do not pause the count.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        d_md_stall = 1'b0;
        case (state_q)
            ST_ISSUE: d_md_stall = !md_if.md_ack;
            ST_WAIT:  d_md_stall = d_valid && (dec_start || dec_hl);
            default:  d_md_stall = 1'b0;
        endcase
    end

    assign e_bubble     = d_md_stall;
    assign md_busy_cnt  = cnt_q;
    assign md_if.md_req = md_req_q;
    assign md_if.md_op  = md_op_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: per-cycle expected observation vectors go
// through an expected queue and are compared at the falling edge.
module tb_md_issue_ctrl;
    import md_defs::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [31:0]      d_instr;
    logic             d_valid;
    logic             e_stall_ext;
    logic [CNT_W-1:0] md_busy_cnt;
    logic             d_md_stall;
    logic             e_bubble;
    md_state_t        dbg_state;

    md_issue_ctrl_if md_if ();

    md_issue_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_instr     (d_instr),
        .d_valid     (d_valid),
        .e_stall_ext (e_stall_ext),
        .md_if       (md_if.master),
        .md_busy_cnt (md_busy_cnt),
        .d_md_stall  (d_md_stall),
        .e_bubble    (e_bubble),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1);
    end

    // scoreboard
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got req=%0b op=%0d cnt=%0d stall=%0b bub=%0b, want req=%0b op=%0d cnt=%0d stall=%0b bub=%0b",
                      tag, got[9], got[8:6], got[5:2], got[1], got[0],
                      exp[9], exp[8:6], exp[5:2], exp[1], exp[0]);
    endtask

    // md_op only carries meaning while md_req is high
    function automatic logic [9:0] observe();
        logic [2:0] op;
        op = md_if.md_req ? 3'(md_if.md_op) : 3'd0;
        return {md_if.md_req, op, md_busy_cnt, d_md_stall, e_bubble};
    endfunction

    function automatic logic [9:0] ev(input logic req, input logic [2:0] op,
                                      input logic [3:0] cnt, input logic st);
        return {req, op, cnt, st, st};
    endfunction

    function automatic logic [31:0] rinst(input logic [5:0] op, input logic [5:0] fn);
        return {op, 5'd3, 5'd4, 5'd5, 5'd0, fn};
    endfunction

    logic [31:0] i_mult, i_multu, i_div, i_addu, i_mfhi, i_mflo, i_mthi, i_mtlo, i_madd, i_msub;

    function automatic logic [31:0] hl_rand();
        case ($urandom_range(0, 3))
            0:       return i_mfhi;
            1:       return i_mflo;
            2:       return i_mthi;
            default: return i_mtlo;
        endcase
    endfunction

    // driver: one cycle of inputs, expectation queued, compared mid-cycle
    task automatic cyc(input logic r, input logic [31:0] instr, input logic v,
                       input logic ext, input logic ack, input logic [9:0] exp,
                       input string tag);
        rst          = r;
        d_instr      = instr;
        d_valid      = v;
        e_stall_ext  = ext;
        md_if.md_ack = ack;
        exp_q.push_back(exp);
        @(negedge clk);
        check_eq(tag, observe(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    localparam logic [2:0] OPM  = 3'(MD_MULT);
    localparam logic [2:0] OPMU = 3'(MD_MULTU);
    localparam logic [2:0] OPD  = 3'(MD_DIV);
    localparam logic [2:0] OPMA = 3'(MD_MADD);
    localparam logic [2:0] OPMS = 3'(MD_MSUB);

    initial begin
        i_mult  = rinst(6'b000000, 6'b011000);
        i_multu = rinst(6'b000000, 6'b011001);
        i_div   = rinst(6'b000000, 6'b011010);
        i_addu  = rinst(6'b000000, 6'b100001);
        i_mfhi  = rinst(6'b000000, 6'b010000);
        i_mflo  = rinst(6'b000000, 6'b010010);
        i_mthi  = rinst(6'b000000, 6'b010001);
        i_mtlo  = rinst(6'b000000, 6'b010011);
        i_madd  = rinst(6'b011100, 6'b000000);
        i_msub  = rinst(6'b011100, 6'b000100);

        rst = 1'b1; d_instr = '0; d_valid = 1'b0; e_stall_ext = 1'b0; md_if.md_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, i_mult, 1, 0, 0, ev(0, 0, 0, 0), "reset_state");

        // bubble carrying a mult encoding must not issue
        cyc(0, i_mult, 0, 0, 0, ev(0, 0, 0, 0), "bubble_idle");
        cyc(0, i_mult, 0, 0, 0, ev(0, 0, 0, 0), "bubble_no_issue");

        // mult, ack two cycles after issue, then HI/LO readers/writers wait it out
        cyc(0, i_mult, 1, 0, 0, ev(0, 0, 0, 0), "mult_idle");
        cyc(0, i_mult, 1, 0, 0, ev(1, OPM, 0, 1), "mult_issue");
        cyc(0, i_mult, 1, 0, 1, ev(1, OPM, 0, 0), "mult_ack");
        for (int i = 5; i >= 1; i--) cyc(0, hl_rand(), 1, 0, 0, ev(0, 0, 4'(i), 1), "hl_wait");
        cyc(0, i_mflo, 1, 0, 0, ev(0, 0, 0, 0), "mflo_release");

        // div, addu passes during WAIT, mfhi stalls to the end of the 10-cycle count
        cyc(0, i_div, 1, 0, 0, ev(0, 0, 0, 0), "div_idle");
        cyc(0, i_div, 1, 0, 1, ev(1, OPD, 0, 0), "div_ack");
        cyc(0, i_addu, 1, 0, 0, ev(0, 0, 10, 0), "addu_pass10");
        cyc(0, i_addu, 1, 0, 0, ev(0, 0, 9, 0), "addu_pass9");
        for (int i = 8; i >= 1; i--) cyc(0, i_mfhi, 1, 0, 0, ev(0, 0, 4'(i), 1), "mfhi_wait");
        cyc(0, i_mfhi, 1, 0, 0, ev(0, 0, 0, 0), "mfhi_release");

        // back-to-back mult, multu; then external freeze and stray ack during WAIT
        cyc(0, i_mult, 1, 0, 0, ev(0, 0, 0, 0), "b2b_idle");
        cyc(0, i_mult, 1, 0, 1, ev(1, OPM, 0, 0), "b2b_ack1");
        for (int i = 5; i >= 1; i--) cyc(0, i_multu, 1, 0, 0, ev(0, 0, 4'(i), 1), "multu_wait");
        cyc(0, i_multu, 1, 0, 0, ev(0, 0, 0, 0), "multu_idle");
        cyc(0, i_multu, 1, 0, 0, ev(1, OPMU, 0, 1), "multu_issue");
        cyc(0, i_multu, 1, 0, 1, ev(1, OPMU, 0, 0), "multu_ack");
        for (int i = 5; i >= 3; i--) cyc(0, i_addu, 0, 1, 0, ev(0, 0, 4'(i), 0), "ext_stall_cnt");
        cyc(0, i_addu, 0, 0, 1, ev(0, 0, 2, 0), "stray_ack");
        cyc(0, i_addu, 0, 0, 1, ev(0, 0, 1, 0), "stray_ack2");
        cyc(0, i_addu, 0, 0, 0, ev(0, 0, 0, 0), "ext_done");

        // e_stall_ext blocks issue from IDLE; in ISSUE the ack still lands
        cyc(0, i_mult, 1, 1, 0, ev(0, 0, 0, 0), "ext_block1");
        cyc(0, i_mult, 1, 1, 0, ev(0, 0, 0, 0), "ext_block2");
        cyc(0, i_mult, 1, 0, 0, ev(0, 0, 0, 0), "ext_lift");
        cyc(0, i_mult, 1, 1, 0, ev(1, OPM, 0, 1), "ext_issue_hold");
        cyc(0, i_mult, 1, 1, 1, ev(1, OPM, 0, 0), "ext_issue_ack");
        for (int i = 5; i >= 1; i--) cyc(0, i_addu, 1, 0, 0, ev(0, 0, 4'(i), 0), "drain");
        cyc(0, i_addu, 1, 0, 0, ev(0, 0, 0, 0), "drain_done");

        // reset mid-WAIT at cnt=7
        cyc(0, i_div, 1, 0, 0, ev(0, 0, 0, 0), "rst_div_idle");
        cyc(0, i_div, 1, 0, 1, ev(1, OPD, 0, 0), "rst_div_ack");
        for (int i = 10; i >= 8; i--) cyc(0, i_mfhi, 1, 0, 0, ev(0, 0, 4'(i), 1), "rst_pre");
        cyc(1, i_mfhi, 1, 0, 0, ev(0, 0, 7, 1), "rst_at7");
        cyc(0, i_mfhi, 1, 0, 0, ev(0, 0, 0, 0), "rst_after");

`ifdef MD_ISSUE_MADD_EN
        cyc(0, i_madd, 1, 0, 0, ev(0, 0, 0, 0), "madd_idle");
        cyc(0, i_madd, 1, 0, 0, ev(1, OPMA, 0, 1), "madd_issue");
        cyc(0, i_madd, 1, 0, 1, ev(1, OPMA, 0, 0), "madd_ack");
        cyc(0, i_msub, 1, 0, 0, ev(0, 0, 5, 1), "msub_wait5");
        for (int i = 4; i >= 1; i--) cyc(0, i_msub, 1, 0, 0, ev(0, 0, 4'(i), 1), "msub_wait");
        cyc(0, i_msub, 1, 0, 0, ev(0, 0, 0, 0), "msub_idle");
        cyc(0, i_msub, 1, 0, 0, ev(1, OPMS, 0, 1), "msub_issue");
        cyc(0, i_msub, 1, 0, 1, ev(1, OPMS, 0, 0), "msub_ack");
        for (int i = 5; i >= 1; i--) cyc(0, i_addu, 0, 0, 0, ev(0, 0, 4'(i), 0), "msub_drain");
        cyc(0, i_addu, 0, 0, 0, ev(0, 0, 0, 0), "msub_done");
`else
        for (int i = 0; i < 3; i++) cyc(0, i_madd, 1, 0, 0, ev(0, 0, 0, 0), "madd_other");
        for (int i = 0; i < 3; i++) cyc(0, i_msub, 1, 0, 0, ev(0, 0, 0, 0), "msub_other");
        // madd in D during a mult WAIT must not stall either
        cyc(0, i_mult, 1, 0, 0, ev(0, 0, 0, 0), "madd_w_idle");
        cyc(0, i_mult, 1, 0, 1, ev(1, OPM, 0, 0), "madd_w_ack");
        for (int i = 5; i >= 1; i--) cyc(0, i_madd, 1, 0, 0, ev(0, 0, 4'(i), 0), "madd_w_pass");
        cyc(0, i_madd, 1, 0, 0, ev(0, 0, 0, 0), "madd_w_done");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
